fpga_io_sequencer: RTL and testbench
====================================

FPGA_IO_SEQUENCER -- requirements
Module: fpga_io_sequencer

Interface
REQ-001 Parameter SS_COUNT, default 8, number of seven-segment digit registers written per display op (1..8).
REQ-002 Parameter SS_BASE, default 8'd0, bus address of digit 0; digit i is at SS_BASE+i.
REQ-003 Parameter LEFT_ADDR, default 8'd8, bus address of the left LED byte.
REQ-004 Parameter RIGHT_ADDR, default 8'd9, bus address of the right LED byte.
REQ-005 Parameter PB_ADDR, default 8'd10, bus address of the pushbutton code register.
REQ-006 clk  in  1  clock, all state updates on the rising edge.
REQ-007 nrst  in  1  reset, asynchronous, active-low.
REQ-008 req_valid  in  1  command request.
REQ-009 req_ready  out  1  sequencer can accept a command.
REQ-010 req_op  in  2  command: 0 DISP, 1 LED, 2 POLL, 3 reserved.
REQ-011 req_data  in  32  command payload.
REQ-012 bus_addr  out  8  IO bus address.
REQ-013 bus_wdata  out  8  IO bus write data.
REQ-014 bus_read_en  out  1  1 = read or idle, 0 = write strobe for the current cycle.
REQ-015 bus_rdata  in  8  IO bus read data, combinational from the responder.
REQ-016 rsp_valid  out  1  one-cycle pulse: poll result available.
REQ-017 rsp_data  out  8  last poll result.

Function
REQ-018 All bus_* outputs and rsp_* outputs SHALL be registered.
REQ-019 States: IDLE, WRITE, READ, RESP; req_ready SHALL be 1 only in IDLE.
REQ-020 A command SHALL be accepted on a cycle with req_valid=1 and req_ready=1; req_op and req_data are captured into internal registers on that edge.
REQ-021 DISP: for beats i=0..SS_COUNT-1 in consecutive cycles, drive bus_addr=SS_BASE+i, bus_wdata={4'b0, captured_data[4i+3:4i]}, bus_read_en=0.
REQ-022 LED: two consecutive write beats: LEFT_ADDR with data[7:0], then RIGHT_ADDR with data[15:8].
REQ-023 The first write beat SHALL appear on the bus in the cycle after acceptance; after the last beat the FSM returns to IDLE, and req_ready=1 in the following cycle.
REQ-024 POLL: one READ cycle with bus_addr=PB_ADDR and bus_read_en=1; bus_rdata is sampled at the end of that cycle into rsp_data.
REQ-025 POLL: RESP cycle follows with rsp_valid=1, then IDLE; rsp_data holds its value until the next POLL.
REQ-026 Reserved op 3 SHALL be accepted and discarded: no bus write, no rsp_valid; the FSM stays in IDLE.
REQ-027 Outside WRITE beats, bus_read_en SHALL be 1, bus_wdata=0, and bus_addr=PB_ADDR; no spurious write strobe is ever driven.
REQ-028 req_valid while busy SHALL be ignored; the requester holds it until req_ready.
REQ-029 The beat counter SHALL be log2-sized to SS_COUNT and SHALL NOT wrap past the last beat.
REQ-030 Changes to req_data after acceptance SHALL NOT affect the beats in flight.

Reset
REQ-031 On nrst=0, immediately: state IDLE, req_ready=1, bus_read_en=1, bus_addr=PB_ADDR, bus_wdata=0, rsp_valid=0, rsp_data=0, counter=0.
REQ-032 Reset mid-command SHALL abort the command; no further write beats occur and no rsp_valid is produced after release.

Structure
REQ-033 A shared package SHALL hold the op enum (DISP/LED/POLL/RSVD), the FSM state typedef and the IO address constants; the IO responder uses the same constants.
REQ-034 The design is a single module with no sub-module; the FSM and beat counter are inline.

Verification
REQ-035 Reset release, then DISP with data 32'h8765_4321 -> writes (addr,data) (0,1),(1,2),...,(7,8) on cycles 1..8 after acceptance; req_ready returns in cycle 10.
REQ-036 LED with data 32'h0000_A55A -> writes (8,0x5A),(9,0xA5) on two consecutive cycles; no other cycle has bus_read_en=0.
REQ-037 POLL with bus_rdata=0x0C during READ -> rsp_valid pulses for one cycle with rsp_data=0x0C; rsp_data holds 0x0C while bus_rdata changes.
REQ-038 req_valid held high with a LED op during an in-flight DISP -> the LED op is accepted only in the first cycle req_ready=1, and its writes follow the complete DISP sequence.
REQ-039 nrst asserted after the 3rd DISP beat -> outputs take reset values asynchronously; after release there are no remaining beats and req_ready=1.
REQ-040 op 3 with data 32'hFFFF_FFFF -> no write strobe, no rsp_valid, and req_ready remains 1.

Source files
------------

// File: rtl/fpga_io_sequencer_pkg.sv
// fpga_io_sequencer_pkg: shared ops, FSM states and IO map for the sequencer and its responder
package fpga_io_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_DISP = 2'd0,
        OP_LED  = 2'd1,
        OP_POLL = 2'd2,
        OP_RSVD = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam int         SS_COUNT_DEF   = 8;
    localparam logic [7:0] SS_BASE_DEF    = 8'd0;
    localparam logic [7:0] LEFT_ADDR_DEF  = 8'd8;
    localparam logic [7:0] RIGHT_ADDR_DEF = 8'd9;
    localparam logic [7:0] PB_ADDR_DEF    = 8'd10;

endpackage

// File: rtl/fpga_io_sequencer.sv
// fpga_io_sequencer: turns display/LED/poll commands into registered IO bus beats
module fpga_io_sequencer
    import fpga_io_sequencer_pkg::*;
#(
    parameter int         SS_COUNT   = SS_COUNT_DEF,
    parameter logic [7:0] SS_BASE    = SS_BASE_DEF,
    parameter logic [7:0] LEFT_ADDR  = LEFT_ADDR_DEF,
    parameter logic [7:0] RIGHT_ADDR = RIGHT_ADDR_DEF,
    parameter logic [7:0] PB_ADDR    = PB_ADDR_DEF
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_data,
    output logic [7:0]  bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        bus_read_en,
    input  logic [7:0]  bus_rdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data
);

    // LED needs two beats, so the counter is never narrower than one bit
    localparam int CW = $clog2(SS_COUNT > 2 ? SS_COUNT : 2);

    state_e        state, state_d;
    op_e           op_q, op_d;
    logic [31:0]   data_q, data_d, shifted;
    logic [CW-1:0] cnt, cnt_d, last;
    logic [7:0]    addr_d, wdata_d, rsp_data_d;
    logic          read_en_d, rsp_valid_d, ready_d, accept;

    assign accept = req_valid && req_ready;

    // next state plus the bus/response values to register for the coming cycle
    always_comb begin
        op_d        = accept ? op_e'(req_op) : op_q;
        data_d      = accept ? req_data : data_q;
        last        = (op_d == OP_DISP) ? CW'(SS_COUNT - 1) : CW'(1);
        state_d     = state;
        cnt_d       = cnt;
        addr_d      = PB_ADDR;
        wdata_d     = 8'h00;
        read_en_d   = 1'b1;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data;
        case (state)
            IDLE: begin
                cnt_d   = '0;
                state_d = !accept ? IDLE :
                          (op_d == OP_DISP || op_d == OP_LED) ? WRITE :
                          (op_d == OP_POLL) ? READ : IDLE;
            end
            WRITE: begin
                state_d = (cnt == last) ? IDLE : WRITE;
                cnt_d   = (cnt == last) ? '0 : cnt + CW'(1);
            end
            READ: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = bus_rdata;
            end
            RESP: state_d = IDLE;
        endcase
        shifted = data_d >> {cnt_d, 2'b00};
        if (state_d == WRITE) begin
            read_en_d = 1'b0;
            addr_d    = (op_d == OP_DISP) ? SS_BASE + 8'(cnt_d) : (cnt_d[0] ? RIGHT_ADDR : LEFT_ADDR);
            wdata_d   = (op_d == OP_DISP) ? {4'b0, shifted[3:0]} : (cnt_d[0] ? data_d[15:8] : data_d[7:0]);
        end
        ready_d = (state == IDLE) && (state_d == IDLE);
    end

    // state, captured command and all registered outputs; reset aborts any command
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            op_q        <= OP_DISP;
            data_q      <= '0;
            cnt         <= '0;
            req_ready   <= 1'b1;
            bus_addr    <= PB_ADDR;
            bus_wdata   <= 8'h00;
            bus_read_en <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_data    <= 8'h00;
        end else begin
            state       <= state_d;
            op_q        <= op_d;
            data_q      <= data_d;
            cnt         <= cnt_d;
            req_ready   <= ready_d;
            bus_addr    <= addr_d;
            bus_wdata   <= wdata_d;
            bus_read_en <= read_en_d;
            rsp_valid   <= rsp_valid_d;
            rsp_data    <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_fpga_io_sequencer.sv
// tb_fpga_io_sequencer: directed and random commands checked cycle by cycle against a trace model
module tb_fpga_io_sequencer;
    import fpga_io_sequencer_pkg::*;

    localparam int N = SS_COUNT_DEF;

    logic        clk = 1'b0, nrst = 1'b1, req_valid = 1'b0, req_ready;
    logic [1:0]  req_op = 2'd0;
    logic [31:0] req_data = '0;
    logic [7:0]  bus_addr, bus_wdata, bus_rdata, rsp_data;
    logic        bus_read_en, rsp_valid;
    logic [7:0]  pb_code = 8'h00, rsp_model = 8'h00;
    int          n_checks = 0, n_errors = 0, n_strobes = 0, exp_strobes = 0;

    always #5 clk = ~clk;

    assign bus_rdata = pb_code;

    fpga_io_sequencer dut (
        .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_data(req_data), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_read_en(bus_read_en), .bus_rdata(bus_rdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data)
    );

    // every write strobe seen anywhere in the run
    always @(negedge clk) if (nrst && !bus_read_en) n_strobes++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] data);
        int t = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_data  = data;
        while (!req_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("accept_timeout", 32'(t < 40), 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_data  = $urandom;
    endtask

    // expected trace for one command, starting right after its acceptance edge
    task automatic check_cycles(input logic [1:0] op, input logic [31:0] data, input logic [7:0] r);
        logic [7:0] ea[$], ed[$];
        int nb, busy;
        pb_code = r;
        if (op == 2'd0)
            for (int i = 0; i < N; i++) begin
                ea.push_back(8'(SS_BASE_DEF + 8'(i)));
                ed.push_back(8'((data >> (4 * i)) & 32'hF));
            end
        else if (op == 2'd1) begin
            ea = '{LEFT_ADDR_DEF, RIGHT_ADDR_DEF};
            ed = '{data[7:0], data[15:8]};
        end
        nb = ea.size();
        busy = (op == 2'd2) ? 2 : nb;
        exp_strobes += nb;
        for (int k = 1; k <= (busy == 0 ? 1 : busy + 2); k++) begin
            logic w;
            @(negedge clk);
            w = (k <= nb);
            if (op == 2'd2 && k == 2) rsp_model = r;
            check("read_en", bus_read_en, !w);
            check("addr", bus_addr, w ? ea[k-1] : PB_ADDR_DEF);
            check("wdata", bus_wdata, w ? ed[k-1] : 8'h00);
            check("rsp_valid", rsp_valid, op == 2'd2 && k == 2);
            check("rsp_data", rsp_data, rsp_model);
            check("req_ready", req_ready, busy == 0 || k == busy + 2);
            if (op == 2'd2 && k == 2) pb_code = r ^ 8'hFF;
        end
    endtask

    initial begin
        #2 nrst = 1'b0;
        #2;
        check("rst_ready", req_ready, 1);
        check("rst_read_en", bus_read_en, 1);
        check("rst_addr", bus_addr, PB_ADDR_DEF);
        check("rst_wdata", bus_wdata, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;

        issue(2'd0, 32'h8765_4321);
        check_cycles(2'd0, 32'h8765_4321, 8'h00);
        issue(2'd1, 32'h0000_A55A);
        check_cycles(2'd1, 32'h0000_A55A, 8'h00);
        issue(2'd2, 32'h0);
        check_cycles(2'd2, 32'h0, 8'h0C);
        check("poll_hold", rsp_data, 8'h0C);

        issue(2'd0, 32'h1234_5678);
        req_valid = 1'b1;
        req_op    = 2'd1;
        req_data  = 32'h0000_3CC3;
        check_cycles(2'd0, 32'h1234_5678, 8'h55);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_data  = $urandom;
        check_cycles(2'd1, 32'h0000_3CC3, 8'h66);

        issue(2'd0, 32'hFEDC_BA98);
        repeat (3) @(negedge clk);
        exp_strobes += 3;
        @(posedge clk);
        #2 nrst = 1'b0;
        #1;
        check("abort_ready", req_ready, 1);
        check("abort_read_en", bus_read_en, 1);
        check("abort_addr", bus_addr, PB_ADDR_DEF);
        check("abort_wdata", bus_wdata, 0);
        check("abort_rsp_data", rsp_data, 0);
        rsp_model = 8'h00;
        @(negedge clk);
        nrst = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("post_rst_read_en", bus_read_en, 1);
            check("post_rst_rsp_valid", rsp_valid, 0);
            check("post_rst_ready", req_ready, 1);
        end

        issue(2'd3, 32'hFFFF_FFFF);
        check_cycles(2'd3, 32'hFFFF_FFFF, 8'h11);

        for (int n = 0; n < 40; n++) begin
            logic [1:0]  op;
            logic [31:0] d;
            op = 2'($urandom_range(0, 3));
            d  = $urandom;
            issue(op, d);
            check_cycles(op, d, 8'($urandom));
        end

        repeat (3) @(negedge clk);
        check("strobe_total", n_strobes, exp_strobes);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
